// File: rtl/omsp_spm_table_if.sv
// omsp_spm_table_if: bus between the core and the SPM table.
// master drives pc/bus/commands, slave (table) returns status and flags.
// Optional DMA guard signals present with SPM_TABLE_DMA_GUARD_EN.
interface omsp_spm_table_if #(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 16,
    parameter int SW     = 2
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] prev_pc;
    logic [ADDR_W-1:0] mab;
    logic              mb_en;
    logic [1:0]        mb_wr;
    logic              verify_rd;
    logic              cmd_create;
    logic              cmd_disable;
    logic [ADDR_W-1:0] r12;
    logic [ADDR_W-1:0] r13;
    logic [ADDR_W-1:0] r14;
    logic [ADDR_W-1:0] r15;
    logic              viol_clr;
    logic              busy;
    logic              done;
    logic [2:0]        status;
    logic [ID_W-1:0]   new_id;
    logic              executing;
    logic [SW-1:0]     exec_idx;
    logic [ID_W-1:0]   exec_id;
    logic              violation;
    logic              viol_sticky;
    logic [SW-1:0]     viol_idx;
`ifdef SPM_TABLE_DMA_GUARD_EN
    logic              dma_en;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_violation;
`endif

    modport master (
        output pc, prev_pc, mab, mb_en, mb_wr, verify_rd,
        output cmd_create, cmd_disable, r12, r13, r14, r15, viol_clr,
`ifdef SPM_TABLE_DMA_GUARD_EN
        output dma_en, dma_addr,
        input  dma_violation,
`endif
        input  busy, done, status, new_id, executing, exec_idx,
        input  exec_id, violation, viol_sticky, viol_idx
    );

    modport slave (
        input  pc, prev_pc, mab, mb_en, mb_wr, verify_rd,
        input  cmd_create, cmd_disable, r12, r13, r14, r15, viol_clr,
`ifdef SPM_TABLE_DMA_GUARD_EN
        input  dma_en, dma_addr,
        output dma_violation,
`endif
        output busy, done, status, new_id, executing, exec_idx,
        output exec_id, violation, viol_sticky, viol_idx
    );
endinterface

// File: rtl/omsp_spm_table.sv
// omsp_spm_table: multi-slot SPM protection table (create/disable FSM,
// per-cycle access checks, sticky violation capture).
// Ports: mclk, puc_rst_n (async active-low), bus (omsp_spm_table_if.slave).
// Optional DMA guard: define SPM_TABLE_DMA_GUARD_EN.
module omsp_spm_table #(
    parameter int NUM_SM = 4,
    parameter int ADDR_W = 16,
    parameter int ID_W   = 16
) (
    input  logic                  mclk,
    input  logic                  puc_rst_n,
    omsp_spm_table_if.slave       bus
);
    localparam int SW = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ALLOC, S_DONE} state_t;

    state_t            r_state, w_next;
    logic              r_valid [NUM_SM];
    logic [ADDR_W-1:0] r_ps    [NUM_SM];
    logic [ADDR_W-1:0] r_pe    [NUM_SM];
    logic [ADDR_W-1:0] r_ss    [NUM_SM];
    logic [ADDR_W-1:0] r_se    [NUM_SM];
    logic [ID_W-1:0]   r_id    [NUM_SM];
    logic [ADDR_W-1:0] r_q12, r_q13, r_q14, r_q15;
    logic [ID_W-1:0]   r_cnt, r_new_id;
    logic [SW-1:0]     r_scan_idx, r_free_idx, r_viol_idx;
    logic              r_fail, r_free_found, r_sticky;
    logic [2:0]        r_status;

    logic              w_cfg_bad, w_scan_ovl, w_alloc, w_dis_clr;
    logic              w_exec, w_violation, w_any;
    logic [SW-1:0]     w_exec_idx, w_any_idx;
    logic [ID_W-1:0]   w_exec_id, w_cnt_nxt;
`ifdef SPM_TABLE_DMA_GUARD_EN
    logic              w_dma_viol;
`endif

    function automatic logic f_in(input logic [ADDR_W-1:0] a,
                                  input logic [ADDR_W-1:0] s,
                                  input logic [ADDR_W-1:0] e);
        return (a >= s) && (a < e);
    endfunction

    function automatic logic f_ovl(input logic [ADDR_W-1:0] as,
                                   input logic [ADDR_W-1:0] ae,
                                   input logic [ADDR_W-1:0] bs,
                                   input logic [ADDR_W-1:0] be);
        return (as < be) && (ae > bs);
    endfunction

    assign w_cfg_bad = (bus.r12 >= bus.r13) || (bus.r14 > bus.r15) ||
                       f_ovl(bus.r12, bus.r13, bus.r14, bus.r15);

    assign w_scan_ovl = r_valid[r_scan_idx] && (
        f_ovl(r_q12, r_q13, r_ps[r_scan_idx], r_pe[r_scan_idx]) ||
        f_ovl(r_q12, r_q13, r_ss[r_scan_idx], r_se[r_scan_idx]) ||
        f_ovl(r_q14, r_q15, r_ps[r_scan_idx], r_pe[r_scan_idx]) ||
        f_ovl(r_q14, r_q15, r_ss[r_scan_idx], r_se[r_scan_idx]));

    // ID 0 is reserved for "no module"
    assign w_cnt_nxt = (r_cnt + 1'b1 == '0) ? ID_W'(1) : r_cnt + 1'b1;
    assign w_alloc   = (r_state == S_ALLOC) && !r_fail && r_free_found;
    assign w_dis_clr = (r_state == S_IDLE) && !bus.cmd_create &&
                       bus.cmd_disable && w_exec;

    // Descending scan so the lowest matching slot wins
    always_comb begin
        w_exec      = 1'b0;
        w_exec_idx  = '0;
        w_exec_id   = '0;
        w_violation = 1'b0;
        w_any       = 1'b0;
        w_any_idx   = '0;
`ifdef SPM_TABLE_DMA_GUARD_EN
        w_dma_viol  = 1'b0;
`endif
        for (int k = NUM_SM - 1; k >= 0; k--) begin
            logic pub, sec, inp, mv, ev, dv;
            pub = f_in(bus.mab, r_ps[k], r_pe[k]);
            sec = f_in(bus.mab, r_ss[k], r_se[k]);
            inp = f_in(bus.pc, r_ps[k], r_pe[k]);
            mv  = bus.mb_en &&
                  ((pub && !((inp && !(|bus.mb_wr)) || bus.verify_rd)) ||
                   (sec && !inp));
            ev  = inp && !f_in(bus.prev_pc, r_ps[k], r_pe[k]) &&
                  (bus.pc != r_ps[k]);
            dv  = 1'b0;
`ifdef SPM_TABLE_DMA_GUARD_EN
            dv  = bus.dma_en &&
                  (f_in(bus.dma_addr, r_ps[k], r_pe[k]) ||
                   f_in(bus.dma_addr, r_ss[k], r_se[k]));
`endif
            if (r_valid[k]) begin
                if (inp) begin
                    w_exec     = 1'b1;
                    w_exec_idx = SW'(k);
                    w_exec_id  = r_id[k];
                end
                if (mv || ev) w_violation = 1'b1;
`ifdef SPM_TABLE_DMA_GUARD_EN
                if (dv) w_dma_viol = 1'b1;
`endif
                if (mv || ev || dv) begin
                    w_any     = 1'b1;
                    w_any_idx = SW'(k);
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_create)
                    w_next = w_cfg_bad ? S_DONE : S_SCAN;
                else if (bus.cmd_disable)
                    w_next = S_DONE;
            end
            S_SCAN: begin
                if (r_scan_idx == SW'(NUM_SM - 1)) w_next = S_ALLOC;
            end
            S_ALLOC: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_q12        <= '0;
            r_q13        <= '0;
            r_q14        <= '0;
            r_q15        <= '0;
            r_scan_idx   <= '0;
            r_free_idx   <= '0;
            r_fail       <= 1'b0;
            r_free_found <= 1'b0;
            r_status     <= '0;
            r_new_id     <= '0;
            r_cnt        <= ID_W'(1);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cmd_create) begin
                        r_q12        <= bus.r12;
                        r_q13        <= bus.r13;
                        r_q14        <= bus.r14;
                        r_q15        <= bus.r15;
                        r_status     <= w_cfg_bad ? 3'd1 : 3'd0;
                        r_scan_idx   <= '0;
                        r_fail       <= 1'b0;
                        r_free_found <= 1'b0;
                    end else if (bus.cmd_disable) begin
                        r_status <= w_exec ? 3'd0 : 3'd4;
                    end
                end
                S_SCAN: begin
                    if (w_scan_ovl) begin
                        r_fail   <= 1'b1;
                        r_status <= 3'd2;
                    end
                    if (!r_valid[r_scan_idx] && !r_free_found) begin
                        r_free_idx   <= r_scan_idx;
                        r_free_found <= 1'b1;
                    end
                    r_scan_idx <= r_scan_idx + 1'b1;
                end
                S_ALLOC: begin
                    if (!r_fail) begin
                        if (!r_free_found) begin
                            r_status <= 3'd3;
                        end else begin
                            r_new_id <= r_cnt;
                            r_cnt    <= w_cnt_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            for (int k = 0; k < NUM_SM; k++) begin
                r_valid[k] <= 1'b0;
                r_ps[k]    <= '0;
                r_pe[k]    <= '0;
                r_ss[k]    <= '0;
                r_se[k]    <= '0;
                r_id[k]    <= '0;
            end
        end else if (w_alloc) begin
            r_valid[r_free_idx] <= 1'b1;
            r_ps[r_free_idx]    <= r_q12;
            r_pe[r_free_idx]    <= r_q13;
            r_ss[r_free_idx]    <= r_q14;
            r_se[r_free_idx]    <= r_q15;
            r_id[r_free_idx]    <= r_cnt;
        end else if (w_dis_clr) begin
            r_valid[w_exec_idx] <= 1'b0;
            r_ps[w_exec_idx]    <= '0;
            r_pe[w_exec_idx]    <= '0;
            r_ss[w_exec_idx]    <= '0;
            r_se[w_exec_idx]    <= '0;
            r_id[w_exec_idx]    <= '0;
        end
    end

    // Clear wins over a same-cycle capture
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_sticky   <= 1'b0;
            r_viol_idx <= '0;
        end else if (bus.viol_clr) begin
            r_sticky   <= 1'b0;
            r_viol_idx <= '0;
        end else if (!r_sticky && w_any) begin
            r_sticky   <= 1'b1;
            r_viol_idx <= w_any_idx;
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.status      = r_status;
    assign bus.new_id      = r_new_id;
    assign bus.executing   = w_exec;
    assign bus.exec_idx    = w_exec_idx;
    assign bus.exec_id     = w_exec_id;
    assign bus.violation   = w_violation;
    assign bus.viol_sticky = r_sticky;
    assign bus.viol_idx    = r_viol_idx;
`ifdef SPM_TABLE_DMA_GUARD_EN
    assign bus.dma_violation = w_dma_viol;
`endif
endmodule

// File: tb/tb_omsp_spm_table.sv
// tb_omsp_spm_table: directed bench for omsp_spm_table, NUM_SM=4.
// Scenario tasks run in sequence from one initial block.
module tb_omsp_spm_table;
    logic mclk;
    logic rst_n;
    int   tests;
    int   fails;

    omsp_spm_table_if #(.ADDR_W(16), .ID_W(16), .SW(2)) bus ();

    omsp_spm_table #(.NUM_SM(4), .ADDR_W(16), .ID_W(16)) dut (
        .mclk      (mclk),
        .puc_rst_n (rst_n),
        .bus       (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic do_cmd(input logic create,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          output int cyc, output logic [2:0] st);
        @(negedge mclk);
        bus.r12 = a;
        bus.r13 = b;
        bus.r14 = c;
        bus.r15 = d;
        bus.cmd_create  = create;
        bus.cmd_disable = !create;
        @(negedge mclk);
        bus.cmd_create  = 1'b0;
        bus.cmd_disable = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge mclk);
            cyc++;
        end
        st = bus.status;
    endtask

    task automatic set_pc(input logic [15:0] p, input logic [15:0] pp);
        bus.pc      = p;
        bus.prev_pc = pp;
        #1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.pc          = 16'h4000;
        bus.prev_pc     = 16'h4000;
        bus.mab         = '0;
        bus.mb_en       = 1'b0;
        bus.mb_wr       = '0;
        bus.verify_rd   = 1'b0;
        bus.cmd_create  = 1'b0;
        bus.cmd_disable = 1'b0;
        bus.r12 = '0;
        bus.r13 = '0;
        bus.r14 = '0;
        bus.r15 = '0;
        bus.viol_clr    = 1'b0;
`ifdef SPM_TABLE_DMA_GUARD_EN
        bus.dma_en   = 1'b0;
        bus.dma_addr = '0;
`endif
        repeat (2) @(negedge mclk);
        tests++;
        if ({bus.busy, bus.done, bus.viol_sticky} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b exp 000",
                     {bus.busy, bus.done, bus.viol_sticky});
        end
        tests++;
        if (bus.status !== 3'd0 || bus.new_id !== 16'd0) begin
            fails++;
            $display("FAIL reset_status got %0d/%0d exp 0/0",
                     bus.status, bus.new_id);
        end
        tests++;
        if (bus.viol_idx !== 2'd0 || bus.executing !== 1'b0) begin
            fails++;
            $display("FAIL reset_idx got %0d/%b exp 0/0",
                     bus.viol_idx, bus.executing);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_create();
        int cyc;
        logic [2:0] st;
        do_cmd(1'b1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, cyc, st);
        tests++;
        if (cyc != 6 || st !== 3'd0 || bus.new_id !== 16'd1) begin
            fails++;
            $display("FAIL create_a got cyc=%0d st=%0d id=%0d exp 6/0/1",
                     cyc, st, bus.new_id);
        end
        do_cmd(1'b1, 16'h8200, 16'h8300, 16'h0300, 16'h0380, cyc, st);
        tests++;
        if (cyc != 6 || st !== 3'd0 || bus.new_id !== 16'd2) begin
            fails++;
            $display("FAIL create_b got cyc=%0d st=%0d id=%0d exp 6/0/2",
                     cyc, st, bus.new_id);
        end
    endtask

    task automatic test_overlap();
        int cyc;
        logic [2:0] st;
        do_cmd(1'b1, 16'h8080, 16'h8180, 16'h0300, 16'h0310, cyc, st);
        tests++;
        if (cyc != 6 || st !== 3'd2 || bus.new_id !== 16'd2) begin
            fails++;
            $display("FAIL overlap got cyc=%0d st=%0d id=%0d exp 6/2/2",
                     cyc, st, bus.new_id);
        end
    endtask

    task automatic test_invalid();
        int cyc;
        logic [2:0] st;
        do_cmd(1'b1, 16'h9000, 16'h9000, 16'h0900, 16'h0910, cyc, st);
        tests++;
        if (cyc != 1 || st !== 3'd1) begin
            fails++;
            $display("FAIL inv_empty got cyc=%0d st=%0d exp 1/1", cyc, st);
        end
        do_cmd(1'b1, 16'h9000, 16'h9100, 16'h0920, 16'h0910, cyc, st);
        tests++;
        if (cyc != 1 || st !== 3'd1) begin
            fails++;
            $display("FAIL inv_sec got cyc=%0d st=%0d exp 1/1", cyc, st);
        end
        do_cmd(1'b1, 16'h9000, 16'h9100, 16'h9050, 16'h9060, cyc, st);
        tests++;
        if (cyc != 1 || st !== 3'd1) begin
            fails++;
            $display("FAIL inv_self got cyc=%0d st=%0d exp 1/1", cyc, st);
        end
    endtask

    task automatic test_full();
        int cyc;
        logic [2:0] st;
        do_cmd(1'b1, 16'h8400, 16'h8500, 16'h0400, 16'h0480, cyc, st);
        tests++;
        if (st !== 3'd0 || bus.new_id !== 16'd3) begin
            fails++;
            $display("FAIL create_c got st=%0d id=%0d exp 0/3",
                     st, bus.new_id);
        end
        do_cmd(1'b1, 16'h8600, 16'h8700, 16'h0500, 16'h0580, cyc, st);
        tests++;
        if (st !== 3'd0 || bus.new_id !== 16'd4) begin
            fails++;
            $display("FAIL create_d got st=%0d id=%0d exp 0/4",
                     st, bus.new_id);
        end
        do_cmd(1'b1, 16'h8800, 16'h8900, 16'h0600, 16'h0680, cyc, st);
        tests++;
        if (cyc != 6 || st !== 3'd3 || bus.new_id !== 16'd4) begin
            fails++;
            $display("FAIL full got cyc=%0d st=%0d id=%0d exp 6/3/4",
                     cyc, st, bus.new_id);
        end
    endtask

    task automatic test_exec();
        @(negedge mclk);
        set_pc(16'h8010, 16'h4000);
        tests++;
        if (bus.violation !== 1'b1) begin
            fails++;
            $display("FAIL exec_mid got %b exp 1", bus.violation);
        end
        @(negedge mclk);
        set_pc(16'h8000, 16'h4000);
        tests++;
        if (bus.viol_sticky !== 1'b1 || bus.viol_idx !== 2'd0) begin
            fails++;
            $display("FAIL sticky0 got %b/%0d exp 1/0",
                     bus.viol_sticky, bus.viol_idx);
        end
        tests++;
        if (bus.violation !== 1'b0 || bus.executing !== 1'b1 ||
            bus.exec_id !== 16'd1 || bus.exec_idx !== 2'd0) begin
            fails++;
            $display("FAIL entry got v=%b x=%b id=%0d idx=%0d exp 0/1/1/0",
                     bus.violation, bus.executing, bus.exec_id,
                     bus.exec_idx);
        end
        @(negedge mclk);
        tests++;
        if (bus.viol_sticky !== 1'b1) begin
            fails++;
            $display("FAIL sticky_hold got %b exp 1", bus.viol_sticky);
        end
        set_pc(16'h8200, 16'h8200);
        tests++;
        if (bus.exec_idx !== 2'd1 || bus.exec_id !== 16'd2) begin
            fails++;
            $display("FAIL exec_b got idx=%0d id=%0d exp 1/2",
                     bus.exec_idx, bus.exec_id);
        end
        bus.viol_clr = 1'b1;
        @(negedge mclk);
        bus.viol_clr = 1'b0;
        tests++;
        if (bus.viol_sticky !== 1'b0) begin
            fails++;
            $display("FAIL clr got %b exp 0", bus.viol_sticky);
        end
        set_pc(16'h8410, 16'h4000);
        @(negedge mclk);
        tests++;
        if (bus.viol_sticky !== 1'b1 || bus.viol_idx !== 2'd2) begin
            fails++;
            $display("FAIL sticky2 got %b/%0d exp 1/2",
                     bus.viol_sticky, bus.viol_idx);
        end
        bus.viol_clr = 1'b1;
        @(negedge mclk);
        tests++;
        if (bus.viol_sticky !== 1'b0) begin
            fails++;
            $display("FAIL clr_prio got %b exp 0", bus.viol_sticky);
        end
        set_pc(16'h4000, 16'h4000);
        @(negedge mclk);
        bus.viol_clr = 1'b0;
    endtask

    task automatic test_mem();
        bus.mb_en = 1'b1;
        bus.mb_wr = 2'b00;
        bus.mab   = 16'h0240;
        set_pc(16'h4000, 16'h4000);
        tests++;
        if (bus.violation !== 1'b1) begin
            fails++;
            $display("FAIL sec_out got %b exp 1", bus.violation);
        end
        set_pc(16'h8010, 16'h800E);
        tests++;
        if (bus.violation !== 1'b0) begin
            fails++;
            $display("FAIL sec_in got %b exp 0", bus.violation);
        end
        bus.mab = 16'h8050;
        #1;
        tests++;
        if (bus.violation !== 1'b0) begin
            fails++;
            $display("FAIL pub_rd_in got %b exp 0", bus.violation);
        end
        bus.mb_wr = 2'b01;
        #1;
        tests++;
        if (bus.violation !== 1'b1) begin
            fails++;
            $display("FAIL pub_wr_in got %b exp 1", bus.violation);
        end
        bus.mb_wr = 2'b00;
        set_pc(16'h4000, 16'h4000);
        tests++;
        if (bus.violation !== 1'b1) begin
            fails++;
            $display("FAIL pub_rd_out got %b exp 1", bus.violation);
        end
        bus.verify_rd = 1'b1;
        #1;
        tests++;
        if (bus.violation !== 1'b0) begin
            fails++;
            $display("FAIL verify_rd got %b exp 0", bus.violation);
        end
        bus.verify_rd = 1'b0;
        bus.mb_en     = 1'b0;
        bus.viol_clr  = 1'b1;
        @(negedge mclk);
        bus.viol_clr  = 1'b0;
    endtask

    task automatic test_disable();
        int cyc;
        logic [2:0] st;
        set_pc(16'h8020, 16'h8020);
        do_cmd(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, cyc, st);
        tests++;
        if (cyc != 1 || st !== 3'd0) begin
            fails++;
            $display("FAIL dis_in got cyc=%0d st=%0d exp 1/0", cyc, st);
        end
        tests++;
        if (bus.executing !== 1'b0) begin
            fails++;
            $display("FAIL dis_clr got %b exp 0", bus.executing);
        end
        set_pc(16'h4000, 16'h4000);
        do_cmd(1'b1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, cyc, st);
        tests++;
        if (st !== 3'd0 || bus.new_id !== 16'd5) begin
            fails++;
            $display("FAIL reuse got st=%0d id=%0d exp 0/5",
                     st, bus.new_id);
        end
        set_pc(16'h8000, 16'h8000);
        tests++;
        if (bus.exec_idx !== 2'd0 || bus.exec_id !== 16'd5) begin
            fails++;
            $display("FAIL reuse_slot got idx=%0d id=%0d exp 0/5",
                     bus.exec_idx, bus.exec_id);
        end
        set_pc(16'h4000, 16'h4000);
        do_cmd(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, cyc, st);
        tests++;
        if (cyc != 1 || st !== 3'd4) begin
            fails++;
            $display("FAIL dis_out got cyc=%0d st=%0d exp 1/4", cyc, st);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        logic [2:0] st;
        @(negedge mclk);
        bus.r12 = 16'hA000;
        bus.r13 = 16'hA100;
        bus.r14 = 16'h0700;
        bus.r15 = 16'h0780;
        bus.cmd_create = 1'b1;
        @(negedge mclk);
        bus.cmd_create = 1'b0;
        @(negedge mclk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_busy got %b exp 0", bus.busy);
        end
        @(negedge mclk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            if (bus.done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_done got %0d pulses exp 0", seen);
        end
        set_pc(16'h8000, 16'h8000);
        tests++;
        if (bus.executing !== 1'b0) begin
            fails++;
            $display("FAIL rst_empty got %b exp 0", bus.executing);
        end
        set_pc(16'h4000, 16'h4000);
        do_cmd(1'b1, 16'h8000, 16'h8100, 16'h0200, 16'h0280, cyc, st);
        tests++;
        if (cyc != 6 || st !== 3'd0 || bus.new_id !== 16'd1) begin
            fails++;
            $display("FAIL rst_recreate got cyc=%0d st=%0d id=%0d exp 6/0/1",
                     cyc, st, bus.new_id);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_create();
        test_overlap();
        test_invalid();
        test_full();
        test_exec();
        test_mem();
        test_disable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/omsp_spm_table.md
Name: omsp_spm_table

Overview:
- Multi-slot successor to the single-module SPM protection unit: holds up to NUM_SM protected modules, each with public (code) and secret (data) ranges, in one table.
- Creation runs a sequential FSM that range-checks the request, scans every slot for overlap, then allocates the lowest free slot.
- Memory-access and entry-point violations are evaluated combinationally against all valid slots every cycle, and the first offender is captured in a sticky register.
- Sits beside the execution unit: driven by pc, prev_pc and the memory bus, with commands coming from the SM instruction decoder.

Parameters:
- NUM_SM, 4, number of module slots (>=1); slot index width SW = max(1, clog2(NUM_SM)).
- ADDR_W, 16, address width of the pc, bus and range registers.
- ID_W, 16, module ID width.

Ports:
- mclk  in  1  clock.
- puc_rst_n  in  1  asynchronous active-low reset.
- pc, prev_pc  in  ADDR_W each  current and previous instruction address.
- mab  in  ADDR_W  memory address bus.
- mb_en  in  1  memory access strobe.
- mb_wr  in  2  byte write enables.
- verify_rd  in  1  current access is an SM verify read (public read allowed).
- cmd_create  in  1  one-cycle create request.
- cmd_disable  in  1  one-cycle disable request.
- r12, r13, r14, r15  in  ADDR_W each  public start, public end, secret start, secret end.
- viol_clr  in  1  clears the sticky violation capture.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  3  result, valid while done=1.
- new_id  out  ID_W  ID assigned by the last successful create.
- executing  out  1  pc is inside a valid slot's public range.
- exec_idx  out  SW  index of that slot (0 when executing=0).
- exec_id  out  ID_W  ID of that slot (0 when executing=0).
- violation  out  1  combinational violation flag.
- viol_sticky  out  1  a violation has been captured.
- viol_idx  out  SW  slot index of the first captured violation.

Behaviour:
- Reset (async, on puc_rst_n low):
  - all slots invalid, ranges 0, IDs 0; ID counter = 1;
  - state IDLE; busy=0, done=0, status=0, new_id=0, viol_sticky=0, viol_idx=0.
  - Reset asserted mid-create aborts the create: no slot is written and no done pulse is issued.
- Ranges are unsigned with exclusive ends; start==end means an empty range.
- Overlap(a,b) = a.start < b.end && a.end > b.start.
- Status codes:
  - 0 OK;
  - 1 invalid config: r12>=r13, or r14>r15, or the request's public range overlaps its own secret range;
  - 2 overlap: any of the four public/secret pairings overlaps a valid slot;
  - 3 table full;
  - 4 disable issued outside any SM.
- FSM states IDLE, SCAN, ALLOC, DONE:
  - IDLE, cmd_create=1: latch r12..r15. If the config is invalid, go to DONE with status 1; otherwise clear scan_idx, clear the fail flag and free_found, and go to SCAN.
  - SCAN, one slot per cycle:
    - a valid slot that overlaps sets fail and status 2;
    - an invalid slot, when free_found=0, records free_idx and sets free_found;
    - after slot NUM_SM-1 is checked, go to ALLOC.
  - ALLOC:
    - if fail, no write;
    - else if no free slot, status 3;
    - else write the slot (valid=1, ranges, id = ID counter), set new_id, and increment the counter; on wrap to 0 the counter is loaded with 1 (ID 0 is never issued).
    - Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Create latency: done is high in the cycle NUM_SM+2 edges after the cmd_create edge; invalid config gives done after 1 edge.
- Disable: accepted only in IDLE.
  - If executing, the exec_idx slot is cleared (valid=0, ranges 0, id 0) at that edge and status 0 is reported.
  - Otherwise status 4 is reported.
  - In both cases state goes to DONE (done on the next cycle).
- Commands while busy=1 are ignored. cmd_create and cmd_disable together in IDLE: create wins.
- Slot changes take effect only at ALLOC or disable edges, so violation checks see the old table during a scan.
- Per valid slot k:
  - pub_k: mab in public_k;
  - sec_k: mab in secret_k;
  - in_k: pc in public_k;
  - mem_viol_k = mb_en & ((pub_k & ~((in_k & ~|mb_wr) | verify_rd)) | (sec_k & ~in_k));
  - exec_viol_k = in_k & ~(prev_pc in public_k) & (pc != public_start_k).
- Combined flags:
  - violation = OR over k of (mem_viol_k | exec_viol_k);
  - executing / exec_idx / exec_id come from the lowest k with in_k (slots never overlap, so this is unique).
- Sticky capture: on the first violation while viol_sticky=0, set viol_sticky and latch the lowest violating k into viol_idx. viol_clr clears it, and clear has priority over capture in the same cycle.

Optional Feature:
- Macro SPM_TABLE_DMA_GUARD_EN.
- With it defined:
  - extra inputs dma_en (1) and dma_addr (ADDR_W), and output dma_violation;
  - dma_violation = dma_en & dma_addr inside any valid slot's public or secret range;
  - dma_violation is also ORed into the sticky capture, with viol_idx set to that slot.
- Without it: the ports are absent and no DMA checking is done.

Test Plan:
- Create (0x8000,0x8100,0x0200,0x0280) after reset, NUM_SM=4 -> done 6 cycles after the request, status 0, new_id=1, slot 0 valid. A second disjoint create gives new_id=2 in slot 1.
- Create (0x8080,0x8180,0x0300,0x0310) with slot 0 as above -> status 2, no slot written, ID counter unchanged.
- Create with r12=0x9000, r13=0x9000 -> done after 1 cycle, status 1. Five disjoint creates -> the fifth returns status 3.
- pc jumps 0x4000->0x8010 -> violation=1, viol_idx=0, viol_sticky stays set until viol_clr. Jump to 0x8000 -> no violation, executing=1, exec_id=1.
- pc=0x4000, mb_en=1, mab=0x0240 -> violation. Same access with pc=0x8010, prev_pc=0x800E -> no violation. Write to 0x8050 from inside the module -> violation.
- cmd_disable at pc=0x8020 -> slot 0 cleared, done with status 0. cmd_disable at pc=0x4000 -> status 4. Reset asserted during SCAN -> no done, table empty.
